// File: rtl/muldiv_sequencer_if.sv
// Command/status bundle between main control and the HI/LO sequencer.
// MULDIV_DZ_EXC_EN adds the dz_exc status line.
interface muldiv_sequencer_if;
    logic       start;
    logic [2:0] op;
    logic       rt_is_zero;
    logic       hilo_read;
    logic       busy;
    logic       done;
    logic       stall_req;
    logic       mult_signed;
    logic       div_signed;
    logic       multy_ena;
    logic       divy_ena;
    logic       hi_ena;
    logic       lo_ena;
    logic [1:0] hi_sel;
    logic [1:0] lo_sel;
    logic       overrun;
`ifdef MULDIV_DZ_EXC_EN
    logic       dz_exc;

    modport master (
        output start, op, rt_is_zero, hilo_read,
        input  busy, done, stall_req, mult_signed, div_signed, multy_ena, divy_ena,
        input  hi_ena, lo_ena, hi_sel, lo_sel, overrun, dz_exc
    );
    modport slave (
        input  start, op, rt_is_zero, hilo_read,
        output busy, done, stall_req, mult_signed, div_signed, multy_ena, divy_ena,
        output hi_ena, lo_ena, hi_sel, lo_sel, overrun, dz_exc
    );
`else
    modport master (
        output start, op, rt_is_zero, hilo_read,
        input  busy, done, stall_req, mult_signed, div_signed, multy_ena, divy_ena,
        input  hi_ena, lo_ena, hi_sel, lo_sel, overrun
    );
    modport slave (
        input  start, op, rt_is_zero, hilo_read,
        output busy, done, stall_req, mult_signed, div_signed, multy_ena, divy_ena,
        output hi_ena, lo_ena, hi_sel, lo_sel, overrun
    );
`endif
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle sequencer for the shared mul/div unit and the HI/LO registers.
// Optional divide-by-zero exception path enabled by MULDIV_DZ_EXC_EN.
module muldiv_sequencer #(
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned DIV_LAT = 32
) (
    input logic            clock,
    input logic            reset,
    muldiv_sequencer_if.slave bus
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StMulRun = 3'd1;
    localparam logic [2:0] StDivRun = 3'd2;
    localparam logic [2:0] StMove   = 3'd3;
    localparam logic [2:0] StWrite  = 3'd4;
    localparam logic [2:0] StZero   = 3'd5;

    logic [2:0] state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic       mult_signed_q, mult_signed_d;
    logic       div_signed_q, div_signed_d;
    logic       is_mul_q, is_mul_d;  // WRITE source: multiplier vs divider
    logic       is_hi_q, is_hi_d;    // MOVE target: HI vs LO
    logic       overrun_q, overrun_d;
    logic       div_by_zero;

`ifdef MULDIV_DZ_EXC_EN
    assign div_by_zero = bus.rt_is_zero;
`else
    logic unused_rt_is_zero;
    assign unused_rt_is_zero = bus.rt_is_zero;
    assign div_by_zero = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mult_signed_d = mult_signed_q;
        div_signed_d  = div_signed_q;
        is_mul_d      = is_mul_q;
        is_hi_d       = is_hi_q;
        overrun_d     = overrun_q | (bus.start & (state_q != StIdle));
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    case (bus.op)
                        3'b000, 3'b001: begin
                            state_d       = StMulRun;
                            cnt_d         = 6'(MUL_LAT - 1);
                            mult_signed_d = ~bus.op[0];
                            is_mul_d      = 1'b1;
                        end
                        3'b010, 3'b011: begin
                            state_d      = div_by_zero ? StZero : StDivRun;
                            cnt_d        = 6'(DIV_LAT - 1);
                            div_signed_d = ~bus.op[0];
                            is_mul_d     = 1'b0;
                        end
                        3'b100, 3'b101: begin
                            state_d = StMove;
                            is_hi_d = ~bus.op[0];
                        end
                        default: ;
                    endcase
                end
            end
            StMulRun, StDivRun: begin
                if (cnt_q == 6'd0) begin
                    state_d = StWrite;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            default: begin
                state_d       = StIdle;
                mult_signed_d = 1'b0;
                div_signed_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= StIdle;
            cnt_q         <= 6'd0;
            mult_signed_q <= 1'b0;
            div_signed_q  <= 1'b0;
            is_mul_q      <= 1'b0;
            is_hi_q       <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mult_signed_q <= mult_signed_d;
            div_signed_q  <= div_signed_d;
            is_mul_q      <= is_mul_d;
            is_hi_q       <= is_hi_d;
            overrun_q     <= overrun_d;
        end
    end

    // Strobes decode registered state only so no input reaches them combinationally.
    logic in_write, in_move;
    assign in_write = (state_q == StWrite);
    assign in_move  = (state_q == StMove);

    assign bus.busy        = (state_q != StIdle);
    assign bus.done        = in_write | in_move | (state_q == StZero);
    assign bus.stall_req   = bus.hilo_read & bus.busy;
    assign bus.mult_signed = mult_signed_q;
    assign bus.div_signed  = div_signed_q;
    assign bus.multy_ena   = (state_q == StMulRun) && (cnt_q == 6'd0);
    assign bus.divy_ena    = (state_q == StDivRun) && (cnt_q == 6'd0);
    assign bus.hi_ena      = in_write | (in_move & is_hi_q);
    assign bus.lo_ena      = in_write | (in_move & ~is_hi_q);
    assign bus.hi_sel      = in_write ? (is_mul_q ? 2'd2 : 2'd0) :
                             ((in_move & is_hi_q) ? 2'd1 : 2'd0);
    assign bus.lo_sel      = in_write ? (is_mul_q ? 2'd2 : 2'd0) :
                             ((in_move & ~is_hi_q) ? 2'd1 : 2'd0);
    assign bus.overrun     = overrun_q;
`ifdef MULDIV_DZ_EXC_EN
    assign bus.dz_exc      = (state_q == StZero);
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: issue pushes expected strobes/done, monitor compares.
module tb_muldiv_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    muldiv_sequencer_if ifc ();

    muldiv_sequencer #(
        .MUL_LAT (2),
        .DIV_LAT (32)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc)
    );

    typedef struct {
        int         cyc;
        logic       hi_ena;
        logic       lo_ena;
        logic [1:0] hi_sel;
        logic [1:0] lo_sel;
        logic       ms;
        logic       ds;
        logic       dz;
    } done_t;

    typedef struct {
        int   cyc;
        logic mul;
    } stb_t;

    done_t done_q[$];
    stb_t  stb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a strobe or done.
    always @(negedge clock) begin
        logic dz;
`ifdef MULDIV_DZ_EXC_EN
        dz = ifc.dz_exc;
`else
        dz = 1'b0;
`endif
        if (ifc.multy_ena || ifc.divy_ena) begin
            if (stb_q.size() == 0) begin
                chk("unexpected_strobe", {ifc.multy_ena, ifc.divy_ena}, 0);
            end else begin
                stb_t s;
                s = stb_q.pop_front();
                chk("strobe_cycle", cyc, s.cyc);
                chk("strobe_kind", {ifc.multy_ena, ifc.divy_ena}, {s.mul, ~s.mul});
            end
        end
        if ((ifc.hi_ena || ifc.lo_ena) && !ifc.done)
            chk("hilo_ena_without_done", {ifc.hi_ena, ifc.lo_ena}, 0);
        if (ifc.done) begin
            if (done_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                done_t d;
                d = done_q.pop_front();
                chk("done_cycle", cyc, d.cyc);
                chk("done_enables", {ifc.hi_ena, ifc.lo_ena}, {d.hi_ena, d.lo_ena});
                chk("done_sels", {ifc.hi_sel, ifc.lo_sel}, {d.hi_sel, d.lo_sel});
                chk("done_signed", {ifc.mult_signed, ifc.div_signed}, {d.ms, d.ds});
                chk("done_dz_exc", dz, d.dz);
            end
        end
    end

    // Drives one start pulse; returns at the negedge after the accept edge.
    task automatic issue(input logic [2:0] op, input bit rz, input bit push_done,
                         input int done_off, input int stb_off, input bit stb_mul,
                         input logic hi_e, input logic lo_e, input logic [1:0] hs,
                         input logic [1:0] ls, input logic ms, input logic ds,
                         input logic dz);
        done_t d;
        stb_t  s;
        @(negedge clock);
        ifc.start      = 1'b1;
        ifc.op         = op;
        ifc.rt_is_zero = rz;
        if (stb_off > 0) begin
            s.cyc = cyc + stb_off;
            s.mul = stb_mul;
            stb_q.push_back(s);
        end
        if (push_done) begin
            d.cyc    = cyc + done_off;
            d.hi_ena = hi_e;
            d.lo_ena = lo_e;
            d.hi_sel = hs;
            d.lo_sel = ls;
            d.ms     = ms;
            d.ds     = ds;
            d.dz     = dz;
            done_q.push_back(d);
        end
        @(negedge clock);
        ifc.start      = 1'b0;
        ifc.rt_is_zero = 1'b0;
    endtask

    task automatic count_busy(input int window, output int n);
        n = 0;
        for (int i = 0; i < window; i++) begin
            if (ifc.busy) n++;
            @(negedge clock);
        end
    endtask

    task automatic drain(input string name);
        repeat (40) @(negedge clock);
        chk(name, done_q.size() + stb_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        ifc.start      = 1'b0;
        ifc.op         = 3'b000;
        ifc.rt_is_zero = 1'b0;
        ifc.hilo_read  = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_busy", ifc.busy, 0);
        chk("reset_overrun", ifc.overrun, 0);
        chk("reset_sels", {ifc.hi_sel, ifc.lo_sel}, 0);
        chk("reset_enables", {ifc.hi_ena, ifc.lo_ena, ifc.multy_ena, ifc.divy_ena, ifc.done}, 0);
        reset = 1'b1;
        @(negedge clock);

        // MULT: strobe +2, WRITE sel=2 at +3, signed
        issue(3'b000, 0, 1, 3, 2, 1, 1, 1, 2'd2, 2'd2, 1, 0, 0);
        count_busy(8, n);
        chk("mult_busy_cycles", n, 3);
        drain("mult_drained");

        // MULTU: unsigned multiply
        issue(3'b001, 0, 1, 3, 2, 1, 1, 1, 2'd2, 2'd2, 0, 0, 0);
        drain("multu_drained");

        // DIVU with MFHI pending: stall for the whole op
        ifc.hilo_read = 1'b1;
        issue(3'b011, 0, 1, 33, 32, 0, 1, 1, 2'd0, 2'd0, 0, 0, 0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (ifc.stall_req) n++;
            @(negedge clock);
        end
        chk("divu_stall_cycles", n, 33);
        chk("divu_stall_after", ifc.stall_req, 0);
        ifc.hilo_read = 1'b0;
        drain("divu_drained");

        // MTLO and MTHI: one-cycle moves
        issue(3'b101, 0, 1, 1, 0, 0, 0, 1, 2'd0, 2'd1, 0, 0, 0);
        count_busy(4, n);
        chk("mtlo_busy_cycles", n, 1);
        issue(3'b100, 0, 1, 1, 0, 0, 1, 0, 2'd1, 2'd0, 0, 0, 0);
        count_busy(4, n);
        chk("mthi_busy_cycles", n, 1);
        drain("move_drained");

        // Illegal ops are ignored
        issue(3'b110, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0);
        chk("illegal6_busy", ifc.busy, 0);
        issue(3'b111, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0);
        chk("illegal7_busy", ifc.busy, 0);
        chk("overrun_still_clear", ifc.overrun, 0);

        // DIV with a MULT start mid-flight: overrun, DIV unaffected
        issue(3'b010, 0, 1, 33, 32, 0, 1, 1, 2'd0, 2'd0, 0, 1, 0);
        repeat (3) @(negedge clock);
        issue(3'b000, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0);
        chk("overrun_set", ifc.overrun, 1);
        chk("overrun_no_mult_signed", ifc.mult_signed, 0);
        drain("overrun_div_drained");
        chk("overrun_sticky", ifc.overrun, 1);

        // Reset while DIV_RUN cnt=10: op aborted, nothing written
        issue(3'b010, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0);
        repeat (21) @(negedge clock);
        chk("pre_reset_busy", ifc.busy, 1);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("abort_busy", ifc.busy, 0);
        reset = 1'b1;
        chk("abort_overrun_cleared", ifc.overrun, 0);
        drain("abort_no_writes");

        // Divide by zero
`ifdef MULDIV_DZ_EXC_EN
        issue(3'b010, 1, 1, 1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 1);
`else
        issue(3'b010, 1, 1, 33, 32, 0, 1, 1, 2'd0, 2'd0, 0, 1, 0);
`endif
        drain("dz_drained");
        chk("final_busy", ifc.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for the shared HI/LO arithmetic resource: the divider, the multiplier, their result registers (dividerY / multyY) and the HI/LO registers.
- The main control unit issues one command per start pulse.
- The block counts out the operation latency, strobes the result-register enables, then writes HI/LO with the correct source selects.
- It requests a pipeline stall while a HI/LO read would see stale data.

Parameters:
MUL_LAT, 2, cycles in MUL_RUN before the multiplier result is valid (legal range 1..63)
DIV_LAT, 32, cycles in DIV_RUN before the divider result is valid (legal range 1..63)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
start  input  1  one-cycle command strobe from main control
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x illegal
rt_is_zero  input  1  divisor==0; sampled only on the cycle a DIV/DIVU start is accepted
hilo_read  input  1  current instruction is MFHI/MFLO
busy  output  1  operation in progress (state != IDLE)
done  output  1  one-cycle pulse, HI/LO write cycle or completion
stall_req  output  1  hilo_read & busy (combinational)
mult_signed  output  1  held from accept until IDLE (1 for MULT)
div_signed  output  1  held from accept until IDLE (1 for DIV)
multy_ena  output  1  multyY capture strobe
divy_ena  output  1  dividerY capture strobe
hi_ena  output  1  HI write enable
lo_ena  output  1  LO write enable
hi_sel  output  2  HI source mux: 0 divider, 1 rs, 2 multiplier
lo_sel  output  2  LO source mux, same encoding as hi_sel
overrun  output  1  sticky: start seen while busy

Behaviour:
- States: IDLE, MUL_RUN, DIV_RUN, MOVE, WRITE. Counter cnt is 6 bits.
- Reset (reset==0 at clock edge):
  - state=IDLE, cnt=0.
  - All outputs 0: sel=0, overrun=0, signed flags=0.
  - Reset aborts any operation mid-flight; HI/LO enables are not asserted afterwards.
- IDLE + start:
  - op MULT/MULTU -> MUL_RUN, cnt=MUL_LAT-1, mult_signed=~op[0].
  - op DIV/DIVU -> DIV_RUN, cnt=DIV_LAT-1, div_signed=~op[0].
  - op MTHI/MTLO -> MOVE.
  - Illegal op: ignored, stays IDLE, no done.
- MUL_RUN / DIV_RUN:
  - cnt decrements each cycle.
  - On the cycle cnt==0, multy_ena (MUL) or divy_ena (DIV) =1; next state WRITE.
  - Total cycles from accept edge to done = LAT+1.
- WRITE:
  - hi_ena=lo_ena=1, done=1 for one cycle, then IDLE.
  - hi_sel=lo_sel=2 after MUL, 0 after DIV.
- MOVE:
  - One cycle; done=1; then IDLE.
  - MTHI: hi_ena=1, hi_sel=1. MTLO: lo_ena=1, lo_sel=1.
  - rs must be held stable by control through this cycle.
- Outputs hi_ena, lo_ena, multy_ena, divy_ena and done are decoded from registered state/cnt only. No input reaches them combinationally.
- busy=1 in every non-IDLE state, including WRITE/MOVE.
- An MFHI/MFLO coinciding with WRITE/MOVE stalls one more cycle; the first non-stalled read sees the new value.
- start while busy: ignored, the operation in progress is unaffected, overrun set to 1 until reset.
- start in the same cycle as done (WRITE/MOVE): counts as busy; ignored and flagged.
- Enables are exactly one cycle wide; never asserted in IDLE.

Optional Feature:
- Macro: MULDIV_DZ_EXC_EN.
- Defined:
  - Adds output port dz_exc (1 bit).
  - DIV/DIVU accepted with rt_is_zero=1 skips DIV_RUN and goes to a ZERO state for one cycle: done=1, dz_exc=1, no hi_ena/lo_ena/divy_ena. HI/LO are unchanged.
  - dz_exc resets to 0.
- Undefined:
  - rt_is_zero is ignored and there is no dz_exc port.
  - Divide by zero runs the full DIV_LAT sequence and writes whatever the divider produces.

Test Plan:
- Reset low for 2 cycles during DIV_RUN cnt=10 -> next cycle IDLE, busy=0, no hi_ena/lo_ena ever pulses for that op.
- MULT start, MUL_LAT=2 -> busy 3 cycles; multy_ena at accept+2; hi_ena=lo_ena=1, sel=2, done at accept+3; mult_signed=1 throughout.
- DIVU start, DIV_LAT=32, hilo_read held 1 -> stall_req=1 for 33 cycles; divy_ena at accept+32; WRITE sel=0 at accept+33; stall_req=0 after.
- MTLO start -> next cycle lo_ena=1, lo_sel=1, hi_ena=0, done=1; busy=1 for exactly one cycle.
- DIV start, then start(MULT) at accept+5 -> overrun=1 (sticky), DIV completes normally at accept+33, no MUL_RUN entered.
- MULDIV_DZ_EXC_EN defined, DIV with rt_is_zero=1 -> next cycle done=1, dz_exc=1, hi_ena=lo_ena=divy_ena=0; undefined -> full 33-cycle sequence with WRITE.
